thermo_gen: RTL and testbench

THERMO_GEN -- requirements
Module: thermo_gen

---
 rtl/thermo_gen_pkg.sv | 26 ++
 rtl/thermo_gen.sv | 94 +++++++++
 tb/tb_thermo_gen.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/thermo_gen_pkg.sv
// Shared definitions for the thermometer-code generator and its matching counter block.
// Holds the FSM state encoding and the fill-select constants both blocks agree on.
package thermo_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] SEL_ONES  = 2'b10;
    localparam logic [1:0] SEL_ZEROS = 2'b01;

    // Any select other than ones/zeros yields an all-zero word.
    function automatic logic fillBit(input logic [1:0] selIn, input logic belowCount);
        logic b;
        b = 1'b0;
        case (selIn)
            SEL_ONES:  b = belowCount;
            SEL_ZEROS: b = ~belowCount;
            default:   b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/thermo_gen.sv
// Thermometer-code word generator: builds a W-bit word one bit per cycle, LSB first,
// with the low 'count' bits set to the fill value and the rest to its complement.
module thermo_gen
    import thermo_gen_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   sel,
    input  logic [W-1:0] cnt_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] word_out
);

    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);
    localparam logic [CW-1:0] SAT_CNT  = CW'(W);
    localparam logic [W-1:0]  MAX_CNT  = W'(W);

    state_e        state_q,    state_d;
    logic [CW-1:0] count_q,    count_d;
    logic [CW-1:0] bitIdx_q,   bitIdx_d;
    logic [1:0]    selLatch_q, selLatch_d;
    logic [W-1:0]  shiftReg_q, shiftReg_d;
    logic [W-1:0]  wordOut_q,  wordOut_d;
    logic          done_q,     done_d;

    // Control flow depends only on start and the bit index, so X on the data
    // inputs can reach the shift register but never the state or handshakes.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        bitIdx_d   = bitIdx_q;
        selLatch_d = selLatch_q;
        shiftReg_d = shiftReg_q;
        wordOut_d  = wordOut_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = BUSY;
                    selLatch_d = sel;
                    count_d    = (cnt_in > MAX_CNT) ? SAT_CNT : cnt_in[CW-1:0];
                    bitIdx_d   = '0;
                    shiftReg_d = '0;
                end
            end
            BUSY: begin
                shiftReg_d = {fillBit(selLatch_q, bitIdx_q < count_q), shiftReg_q[W-1:1]};
                bitIdx_d   = bitIdx_q + 1'b1;
                if (bitIdx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                wordOut_d = shiftReg_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            bitIdx_q   <= '0;
            selLatch_q <= '0;
            shiftReg_q <= '0;
            wordOut_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            bitIdx_q   <= bitIdx_d;
            selLatch_q <= selLatch_d;
            shiftReg_q <= shiftReg_d;
            wordOut_q  <= wordOut_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == BUSY);
    assign done     = done_q;
    assign word_out = wordOut_q;

endmodule

// File: tb/tb_thermo_gen.sv
// Self-checking bench for thermo_gen: directed and random words compared against an
// arithmetic thermometer-code model, plus latency, pulse-count and reset-abort checks.
module tb_thermo_gen;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   sel;
    logic [W-1:0] cnt_in;
    logic         busy;
    logic         done;
    logic [W-1:0] word_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    thermo_gen #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sel      (sel),
        .cnt_in   (cnt_in),
        .busy     (busy),
        .done     (done),
        .word_out (word_out)
    );

    // Low n bits form a mask of ones; the select decides whether that mask is the word,
    // its complement, or nothing at all.
    function automatic logic [W-1:0] expectWord(input int cnt, input logic [1:0] s);
        int           n;
        logic [W-1:0] ones;
        n    = (cnt > W) ? W : cnt;
        ones = W'((64'd1 << n) - 64'd1);
        case (s)
            2'b10:   return ones;
            2'b01:   return ~ones;
            default: return '0;
        endcase
    endfunction

    function automatic int countFill(input logic [W-1:0] w, input logic [1:0] s);
        case (s)
            2'b10:   return $countones(w);
            2'b01:   return W - $countones(w);
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One word: pulse start, then watch W+3 edges. If disturbAt is nonzero, start is
    // raised with junk data for the single edge following sample disturbAt.
    task automatic applyStimulus(input int cnt, input logic [1:0] s, input int disturbAt, input string tag);
        int           doneCount;
        int           firstDone;
        int           busyCount;
        logic [W-1:0] exp;
        exp = expectWord(cnt, s);
        @(negedge clk);
        start  = 1'b1;
        cnt_in = W'(cnt);
        sel    = s;
        @(posedge clk);
        #1;
        start     = 1'b0;
        busyCount = busy ? 1 : 0;
        doneCount = 0;
        firstDone = -1;
        for (int k = 1; k <= W + 3; k++) begin
            @(posedge clk);
            #1;
            if (k == disturbAt + 1) start = 1'b0;
            if (busy) busyCount++;
            if (done) begin
                doneCount++;
                if (firstDone < 0) begin
                    firstDone = k;
                    checkOutput({tag, " word"}, 32'(word_out), 32'(exp));
                end
            end
            if (k == disturbAt) begin
                start  = 1'b1;
                cnt_in = W'($urandom_range(0, 255));
                sel    = 2'($urandom);
            end
        end
        checkOutput({tag, " latency"}, firstDone, W + 1);
        checkOutput({tag, " done pulses"}, doneCount, 1);
        checkOutput({tag, " busy cycles"}, busyCount, W);
        checkOutput({tag, " busy idle"}, 32'(busy), 32'd0);
        checkOutput({tag, " word held"}, 32'(word_out), 32'(exp));
    endtask

    initial begin
        int           c;
        logic [1:0]   s;
        int           d;
        int           seen;
        int           lastDone;
        int           abortDones;
        logic [W-1:0] expQ[$];

        rst    = 1'b1;
        start  = 1'b0;
        sel    = 2'b00;
        cnt_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset word", 32'(word_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(3, 2'b10, 0, "ones3");
        checkOutput("ones3 literal", 32'(word_out), 32'h07);

        applyStimulus(6, 2'b01, 0, "zeros6");
        checkOutput("zeros6 literal", 32'(word_out), 32'hC0);
        checkOutput("zeros6 recount", countFill(word_out, 2'b01), 6);

        applyStimulus(0, 2'b10, 0, "ones0");
        applyStimulus(200, 2'b10, 0, "ones200");
        applyStimulus(8, 2'b10, 0, "ones8");
        checkOutput("ones8 literal", 32'(word_out), 32'hFF);

        // Second start mid-word must be ignored.
        applyStimulus(2, 2'b10, 3, "restart");
        checkOutput("restart literal", 32'(word_out), 32'h03);

        // Start raised during DONE must also be ignored.
        applyStimulus(4, 2'b01, W, "startInDone");

        applyStimulus(5, 2'b00, 0, "nofill00");
        applyStimulus(5, 2'b11, 0, "nofill11");

        // Reset in the middle of a word: no done, word cleared, IDLE afterwards.
        applyStimulus(8, 2'b10, 0, "preAbort");
        @(negedge clk);
        start  = 1'b1;
        cnt_in = W'(5);
        sel    = 2'b10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort busy before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort word", 32'(word_out), 32'd0);
        abortDones = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) abortDones++;
        end
        checkOutput("abort quiet", abortDones, 0);
        applyStimulus(1, 2'b10, 0, "postAbort");
        checkOutput("postAbort literal", 32'(word_out), 32'h01);

        // Start held high: words follow back to back, one done every W+2 edges.
        @(negedge clk);
        c      = $urandom_range(0, 10);
        s      = 2'($urandom);
        cnt_in = W'(c);
        sel    = s;
        expQ.push_back(expectWord(c, s));
        start    = 1'b1;
        seen     = 0;
        lastDone = -1;
        for (int e = 1; e <= 5 * (W + 2) + 5 && seen < 4; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen++;
                checkOutput("stream word", 32'(word_out), 32'(expQ.pop_front()));
                if (lastDone >= 0) checkOutput("stream period", e - lastDone, W + 2);
                lastDone = e;
                c        = $urandom_range(0, 10);
                s        = 2'($urandom);
                cnt_in   = W'(c);
                sel      = s;
                expQ.push_back(expectWord(c, s));
            end
        end
        start = 1'b0;
        checkOutput("stream dones", seen, 4);

        for (int t = 0; t < 12; t++) begin
            c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, W);
            s = 2'($urandom);
            d = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, W);
            applyStimulus(c, s, d, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
